dm_run_control: RTL and testbench
=================================

# dm_run_control

Multi-hart run-control engine for the debug module. It sits between the DMI port (fed by the debug transfer module) and up to 16 core wrappers. It decodes `dmcontrol`/`dmstatus` accesses and runs one halt/resume state machine per hart. It drives per-hart halt and resume requests and aggregates hart status. It generalises the current single-hart halt/exec wiring to `NHARTS` harts, with hart selection, resume acknowledgement and `ndmreset`.

## Interface
- `NHARTS`, default 2: number of harts, legal range 1..16.
- `HARTSEL_W`, default 4: implemented `hartsello` bits; requires `2**HARTSEL_W >= NHARTS`.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  DMI request valid.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_addr`  in  7  DM register address.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  response valid; held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_err`  out  1  unsupported address.
- `halted`  in  NHARTS  per-hart halted status from the cores.
- `halt_req`  out  NHARTS  per-hart halt request (level).
- `resume_req`  out  NHARTS  per-hart resume request (level).
- `ndmreset`  out  1  system reset request, excluding the DM.
- `dmactive`  out  1  DM active.

## Operation
- Registers:
  - `dmcontrol` at 0x10: [31] haltreq, [30] resumereq, [25:16] hartsello (low `HARTSEL_W` bits stored, upper bits read 0), [1] ndmreset, [0] dmactive.
  - `dmstatus` at 0x11, read-only: [17] allresumeack, [16] anyresumeack, [15] allnonexistent, [14] anynonexistent, [11] allrunning, [10] anyrunning, [9] allhalted, [8] anyhalted, [7] authenticated=1, [3:0] version=2.
- Any other address: writes are ignored; the response has `rsp_err`=1 and `rdata`=0. Writes to 0x11 are ignored with `rsp_err`=0.
- `dmcontrol` readback: haltreq, hartsello, ndmreset and dmactive are stored; resumereq always reads 0.
- While dmactive=0:
  - A write to 0x10 updates only dmactive; every other field is forced to 0.
  - `halt_req`/`resume_req` = 0.
  - Each hart FSM is held at HALTED if `halted[i]`, else RUNNING.
  - Resumeack flags are cleared.
- Per-hart FSM, states RUNNING, HALT_PEND, HALTED, RESUME_PEND:
  - RUNNING: `halted[i]`=1 → HALTED (covers ebreak and triggers). A haltreq=1 write selecting hart i → HALT_PEND.
  - HALT_PEND: `halt_req[i]`=1. `halted[i]`=1 → HALTED. A write with haltreq=0 selecting hart i → RUNNING.
  - HALTED: a write with resumereq=1 and haltreq=0 selecting hart i → RESUME_PEND, and resumeack[i] is cleared.
  - RESUME_PEND: `resume_req[i]`=1. `halted[i]`=0 → RUNNING, and resumeack[i] is set.
- Priority and ignored requests:
  - haltreq and resumereq both set → haltreq wins and resumereq is ignored.
  - resumereq to a hart not in HALTED is ignored.
  - haltreq to a hart already HALTED has no effect.
- hartsel ≥ NHARTS: requests are ignored. dmstatus shows any/allnonexistent=1 and all other any/all bits 0.
- dmstatus reflects the selected hart only. With one hart selected, any* equals all*.
- "running" means state RUNNING or HALT_PEND.

## Timing
- Reset values: `req_ready`=1; `rsp_valid`, `rsp_rdata`, `rsp_err`, `halt_req`, `resume_req`, `ndmreset`, `dmactive` = 0. All FSMs are RUNNING and all resumeacks are 0.
- Request handshake:
  - `req_ready` = !`rsp_valid`, so at most one transaction is outstanding.
  - The response appears the cycle after acceptance.
  - The response is held stable until `rsp_valid & rsp_ready`.
  - The next request may be accepted the cycle after the response is consumed.
- Register write effects are visible one cycle after acceptance: FSM state, `halt_req`/`resume_req`, `ndmreset`, `dmactive`.
- `halted` is sampled once per cycle; a state change is visible on outputs the next cycle.
- Simultaneous events in one cycle:
  - A `halted[i]` rise and a haltreq=0 write in HALT_PEND → HALTED.
  - A `halted[i]` rise in RUNNING and a haltreq write → HALTED.
- A read of dmstatus returns the status sampled in the acceptance cycle.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous), and the pending response is dropped.

## Structure
- Package `dm_pkg` holds:
  - the address constants `DM_DMCONTROL`=0x10 and `DM_DMSTATUS`=0x11;
  - packed structs `dmcontrol_t` and `dmstatus_t`;
  - enum `hart_state_e`.
- Sub-module `dm_hart_fsm` (one per hart, via generate) owns the per-hart state machine and resumeack. Its inputs are `sel`, `wr_halt`, `wr_nohalt`, `wr_resume`, `active` and `halted`. Its outputs are `halt_req`, `resume_req`, `is_halted`, `is_running` and `resumeack`.
- The top level owns the DMI handshake, the dmcontrol register and dmstatus aggregation.

## Test plan
- Reset, then read 0x11 → `rsp_rdata`=0x0000_0C82 (all/anyrunning, authenticated, version 2). `rsp_err`=0.
- Write 0x10=0x0000_0001, then 0x8000_0001 (hart 0) → `halt_req[0]`=1 one cycle after acceptance. Drive `halted[0]`=1 → `halt_req[0]`=0. A dmstatus read shows all/anyhalted=1.
- With hart 0 halted, write 0x4000_0001 → `resume_req[0]`=1 and allresumeack=0. Drop `halted[0]` → `resume_req[0]`=0, then allresumeack=anyresumeack=1.
- NHARTS=2, write 0x8003_0001 (hartsel=3) → no `halt_req` bit set. dmstatus = 0x0000_C082.
- Write 0x0000_0003 → `ndmreset`=1. Write 0 → `dmactive`=0 and readback of 0x10 = 0. Write 0xC000_0000 with dmactive=0 → no requests issued.
- Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` and data stay stable and `req_ready`=0. Assert `rst` mid-response → all outputs return to reset values immediately.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the debug-module run-control block: register
// addresses, dmcontrol/dmstatus layouts and the per-hart run state.
package dm_pkg;

   localparam logic [6:0] DM_DMCONTROL = 7'h10;
   localparam logic [6:0] DM_DMSTATUS  = 7'h11;
   localparam logic [3:0] DM_VERSION   = 4'd2;

   typedef struct packed {
      logic       haltreq;
      logic       resumereq;
      logic [3:0] zero1;
      logic [9:0] hartsello;
      logic [13:0] zero0;
      logic       ndmreset;
      logic       dmactive;
   } dmcontrol_t;

   typedef struct packed {
      logic [13:0] zero2;
      logic        allresumeack;
      logic        anyresumeack;
      logic        allnonexistent;
      logic        anynonexistent;
      logic [1:0]  zero1;
      logic        allrunning;
      logic        anyrunning;
      logic        allhalted;
      logic        anyhalted;
      logic        authenticated;
      logic [2:0]  zero0;
      logic [3:0]  version;
   } dmstatus_t;

   typedef enum logic [1:0] {
      HS_RUNNING,
      HS_HALT_PEND,
      HS_HALTED,
      HS_RESUME_PEND
   } hart_state_e;

   // Only one hart is ever selected, so each any*/all* pair carries the same bit.
   function automatic dmstatus_t make_dmstatus(input logic exists,
                                               input logic is_halted,
                                               input logic is_running,
                                               input logic resumeack);
      dmstatus_t s;
      s                = '0;
      s.allresumeack   = resumeack;
      s.anyresumeack   = resumeack;
      s.allnonexistent = ~exists;
      s.anynonexistent = ~exists;
      s.allrunning     = is_running;
      s.anyrunning     = is_running;
      s.allhalted      = is_halted;
      s.anyhalted      = is_halted;
      s.authenticated  = 1'b1;
      s.version        = DM_VERSION;
      return s;
   endfunction

endpackage

// File: rtl/dm_hart_fsm.sv
// Halt/resume state machine and resume acknowledge flag for a single hart.
module dm_hart_fsm
   import dm_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic sel,
   input  logic wr_halt,
   input  logic wr_nohalt,
   input  logic wr_resume,
   input  logic active,
   input  logic halted,
   output logic halt_req,
   output logic resume_req,
   output logic is_halted,
   output logic is_running,
   output logic resumeack
);

   hart_state_e state_q, state_d;
   logic        ack_q, ack_d;

   // NOTE: state registers use non-blocking assignments so every flop in the
   // design samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= HS_RUNNING;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
      end
   end

   // NOTE: hold values are assigned before any branch so no path through this
   // block leaves state_d/ack_d unassigned, which would infer a latch.
   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      if (!active) begin
         state_d = halted ? HS_HALTED : HS_RUNNING;
         ack_d   = 1'b0;
      end else begin
         unique case (state_q)
            HS_RUNNING: begin
               if (halted)               state_d = HS_HALTED;
               else if (sel && wr_halt)  state_d = HS_HALT_PEND;
            end
            HS_HALT_PEND: begin
               if (halted)                 state_d = HS_HALTED;
               else if (sel && wr_nohalt)  state_d = HS_RUNNING;
            end
            HS_HALTED: begin
               if (sel && wr_resume) begin
                  state_d = HS_RESUME_PEND;
                  ack_d   = 1'b0;
               end
            end
            HS_RESUME_PEND: begin
               if (!halted) begin
                  state_d = HS_RUNNING;
                  ack_d   = 1'b1;
               end
            end
         endcase
      end
   end

   assign halt_req   = (state_q == HS_HALT_PEND);
   assign resume_req = (state_q == HS_RESUME_PEND);
   assign is_halted  = (state_q == HS_HALTED)  || (state_q == HS_RESUME_PEND);
   assign is_running = (state_q == HS_RUNNING) || (state_q == HS_HALT_PEND);
   assign resumeack  = ack_q;

endmodule

// File: rtl/dm_run_control.sv
// Debug-module run control: DMI request/response handshake, dmcontrol register,
// dmstatus aggregation for the selected hart and one run-control FSM per hart.
module dm_run_control
   import dm_pkg::*;
#(
   parameter int NHARTS    = 2,
   parameter int HARTSEL_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [6:0]        req_addr,
   input  logic              req_wr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   input  logic [NHARTS-1:0] halted,
   output logic [NHARTS-1:0] halt_req,
   output logic [NHARTS-1:0] resume_req,
   output logic              ndmreset,
   output logic              dmactive
);

   dmcontrol_t           wcmd;
   dmcontrol_t           ctrl_rd;
   dmstatus_t            status_rd;
   logic                 req_fire;
   logic                 ctrl_wr;
   logic                 ctrl_eff;
   logic                 wr_halt, wr_nohalt, wr_resume;
   logic                 haltreq_q, ndmreset_q, dmactive_q;
   logic [HARTSEL_W-1:0] hartsel_q;
   logic [HARTSEL_W-1:0] wsel;
   logic [NHARTS-1:0]    hart_sel;
   logic [NHARTS-1:0]    hart_halted, hart_running, hart_ack;
   logic                 sel_exists, sel_halted, sel_running, sel_ack;
   logic [31:0]          rdata_d;
   logic                 err_d;
   logic                 unused_wdata;

   assign req_ready = ~rsp_valid;
   assign req_fire  = req_valid & req_ready;
   assign wcmd      = dmcontrol_t'(req_wdata);
   assign wsel      = wcmd.hartsello[HARTSEL_W-1:0];
   assign ctrl_wr   = req_fire & req_wr & (req_addr == DM_DMCONTROL);

   // A write only carries requests when the DM is active before and after it;
   // any write that leaves or finds the DM inactive clears every other field.
   assign ctrl_eff  = ctrl_wr & dmactive_q & wcmd.dmactive;
   assign wr_halt   = ctrl_eff & wcmd.haltreq;
   assign wr_nohalt = ctrl_eff & ~wcmd.haltreq;
   assign wr_resume = ctrl_eff & ~wcmd.haltreq & wcmd.resumereq;

   assign unused_wdata = ^req_wdata;

   always_comb begin
      hart_sel = '0;
      for (int i = 0; i < NHARTS; i++) begin
         hart_sel[i] = (wsel == HARTSEL_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dmactive_q <= 1'b0;
         haltreq_q  <= 1'b0;
         hartsel_q  <= '0;
         ndmreset_q <= 1'b0;
      end else if (ctrl_wr) begin
         dmactive_q <= wcmd.dmactive;
         haltreq_q  <= ctrl_eff & wcmd.haltreq;
         hartsel_q  <= ctrl_eff ? wsel : '0;
         ndmreset_q <= ctrl_eff & wcmd.ndmreset;
      end
   end

   assign ndmreset = ndmreset_q;
   assign dmactive = dmactive_q;

   for (genvar g = 0; g < NHARTS; g++) begin : g_hart
      dm_hart_fsm u_fsm (
         .clk        (clk),
         .rst        (rst),
         .sel        (hart_sel[g]),
         .wr_halt    (wr_halt),
         .wr_nohalt  (wr_nohalt),
         .wr_resume  (wr_resume),
         .active     (dmactive_q),
         .halted     (halted[g]),
         .halt_req   (halt_req[g]),
         .resume_req (resume_req[g]),
         .is_halted  (hart_halted[g]),
         .is_running (hart_running[g]),
         .resumeack  (hart_ack[g])
      );
   end

   // A hartsel with no matching hart leaves every per-hart status bit at 0.
   always_comb begin
      sel_exists  = 1'b0;
      sel_halted  = 1'b0;
      sel_running = 1'b0;
      sel_ack     = 1'b0;
      for (int i = 0; i < NHARTS; i++) begin
         if (hartsel_q == HARTSEL_W'(i)) begin
            sel_exists  = 1'b1;
            sel_halted  = hart_halted[i];
            sel_running = hart_running[i];
            sel_ack     = hart_ack[i];
         end
      end
   end

   assign status_rd = make_dmstatus(sel_exists, sel_halted, sel_running, sel_ack);

   always_comb begin
      ctrl_rd           = '0;
      ctrl_rd.haltreq   = haltreq_q;
      ctrl_rd.hartsello = 10'(hartsel_q);
      ctrl_rd.ndmreset  = ndmreset_q;
      ctrl_rd.dmactive  = dmactive_q;
   end

   always_comb begin
      rdata_d = '0;
      err_d   = 1'b0;
      case (req_addr)
         DM_DMCONTROL: if (!req_wr) rdata_d = ctrl_rd;
         DM_DMSTATUS:  if (!req_wr) rdata_d = status_rd;
         default:      err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (req_fire) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= rdata_d;
         rsp_err   <= err_d;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dm_run_control.sv
// Self-checking bench for dm_run_control: directed test-plan sequence with
// literal expectations, then randomized traffic against a behavioural model.
module tb_dm_run_control;

   localparam int NH = 2;
   localparam int HW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [6:0]    req_addr = '0;
   logic          req_wr = 1'b0;
   logic [31:0]   req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [NH-1:0] halted = '0;
   logic [NH-1:0] halt_req;
   logic [NH-1:0] resume_req;
   logic          ndmreset;
   logic          dmactive;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dm_run_control #(.NHARTS(NH), .HARTSEL_W(HW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_wr     (req_wr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .halted     (halted),
      .halt_req   (halt_req),
      .resume_req (resume_req),
      .ndmreset   (ndmreset),
      .dmactive   (dmactive)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model: per hart, "believed halted", pending halt, pending
   // resume and resume-acknowledged flags, plus the dmcontrol contents.
   bit          m_active, m_haltreq, m_ndm;
   bit [3:0]    m_hartsel;
   bit [NH-1:0] m_hh, m_hp, m_rp, m_ack;
   bit          m_rsp_valid, m_err, m_acc;
   bit [31:0]   m_rdata;

   function automatic logic [31:0] status_word();
      logic [31:0] s;
      int          h;
      if (m_hartsel >= NH) return 32'h0000_C082;
      h = int'(m_hartsel);
      s = 32'h0000_0082;
      if (m_hh[h])  s = s | 32'h0000_0300;
      else          s = s | 32'h0000_0C00;
      if (m_ack[h]) s = s | 32'h0003_0000;
      return s;
   endfunction

   always @(posedge clk or negedge rst) begin : model
      bit acc, wr, eff;
      bit [NH-1:0] n_hh, n_hp, n_rp, n_ack;
      int tgt;
      if (!rst) begin
         m_active <= 0; m_haltreq <= 0; m_ndm <= 0; m_hartsel <= 0;
         m_hh <= 0; m_hp <= 0; m_rp <= 0; m_ack <= 0;
         m_rsp_valid <= 0; m_err <= 0; m_acc <= 0; m_rdata <= 0;
      end else begin
         acc = req_valid && !m_rsp_valid;
         m_acc <= acc;
         if (acc) begin
            m_rsp_valid <= 1;
            m_err <= !(req_addr == 7'h10 || req_addr == 7'h11);
            if (req_wr)                m_rdata <= 0;
            else if (req_addr == 7'h10) m_rdata <= {m_haltreq, 11'b0, m_hartsel, 14'b0, m_ndm, m_active};
            else if (req_addr == 7'h11) m_rdata <= status_word();
            else                       m_rdata <= 0;
         end else if (m_rsp_valid && rsp_ready) begin
            m_rsp_valid <= 0;
         end
         wr  = acc && req_wr && (req_addr == 7'h10);
         eff = wr && m_active && req_wdata[0];
         tgt = int'(req_wdata[19:16]);
         n_hh = m_hh; n_hp = m_hp; n_rp = m_rp; n_ack = m_ack;
         for (int i = 0; i < NH; i++) begin
            if (!m_active) begin
               n_hh[i] = halted[i]; n_hp[i] = 0; n_rp[i] = 0; n_ack[i] = 0;
            end else if (!m_hh[i]) begin
               if (halted[i]) begin
                  n_hh[i] = 1; n_hp[i] = 0;
               end else if (eff && tgt == i) begin
                  n_hp[i] = req_wdata[31];
               end
            end else if (m_rp[i]) begin
               if (!halted[i]) begin
                  n_hh[i] = 0; n_rp[i] = 0; n_ack[i] = 1;
               end
            end else if (eff && tgt == i && req_wdata[30] && !req_wdata[31]) begin
               n_rp[i] = 1; n_ack[i] = 0;
            end
         end
         m_hh <= n_hh; m_hp <= n_hp; m_rp <= n_rp; m_ack <= n_ack;
         if (wr) begin
            m_active  <= req_wdata[0];
            m_haltreq <= eff && req_wdata[31];
            m_hartsel <= eff ? req_wdata[19:16] : 4'd0;
            m_ndm     <= eff && req_wdata[1];
         end
      end
   end

   always @(negedge clk) begin
      check("req_ready", req_ready, !m_rsp_valid);
      check("rsp_valid", rsp_valid, m_rsp_valid);
      if (m_rsp_valid) begin
         check("rsp_rdata", rsp_rdata, m_rdata);
         check("rsp_err", rsp_err, m_err);
      end
      check("halt_req", halt_req, m_hp);
      check("resume_req", resume_req, m_rp);
      check("ndmreset", ndmreset, m_ndm);
      check("dmactive", dmactive, m_active);
   end

   // Called at a falling edge; returns at the falling edge after the response
   // was first visible (consumed there if rsp_ready is high).
   task automatic dmi(input logic [6:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
      bit done = 0;
      req_addr = a; req_wr = w; req_wdata = d; req_valid = 1'b1;
      for (int k = 0; k < 20 && !done; k++) begin
         if (!m_rsp_valid) done = 1;
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("dmi_accept", done, 1);
      rd = rsp_rdata;
      er = rsp_err;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [31:0] held;

      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      dmi(7'h11, 0, 0, rd, er);
      check("reset_dmstatus", rd, 32'h0000_0C82);
      check("reset_dmstatus_err", er, 0);

      dmi(7'h10, 1, 32'h0000_0001, rd, er);
      dmi(7'h10, 1, 32'h8000_0001, rd, er);
      check("haltreq_hart0", halt_req, 2'b01);
      halted[0] = 1'b1;
      @(negedge clk);
      check("haltreq_dropped", halt_req, 2'b00);
      dmi(7'h11, 0, 0, rd, er);
      check("status_halted", rd, 32'h0000_0382);

      dmi(7'h10, 1, 32'h4000_0001, rd, er);
      check("resumereq_hart0", resume_req, 2'b01);
      dmi(7'h11, 0, 0, rd, er);
      check("resumeack_cleared", rd[17:16], 2'b00);
      halted[0] = 1'b0;
      @(negedge clk);
      check("resumereq_dropped", resume_req, 2'b00);
      dmi(7'h11, 0, 0, rd, er);
      check("status_resumed", rd, 32'h0003_0C82);

      dmi(7'h10, 1, 32'h8003_0001, rd, er);
      check("nonexistent_no_halt", halt_req, 2'b00);
      dmi(7'h11, 0, 0, rd, er);
      check("status_nonexistent", rd, 32'h0000_C082);

      dmi(7'h10, 1, 32'h0000_0003, rd, er);
      check("ndmreset_set", ndmreset, 1);
      dmi(7'h10, 1, 32'h0000_0000, rd, er);
      check("dmactive_cleared", dmactive, 0);
      dmi(7'h10, 0, 0, rd, er);
      check("dmcontrol_inactive", rd, 32'h0000_0000);
      dmi(7'h10, 1, 32'hC000_0000, rd, er);
      check("inactive_no_req", {halt_req, resume_req}, 4'b0000);
      dmi(7'h10, 0, 0, rd, er);
      check("dmcontrol_still_zero", rd, 32'h0000_0000);

      dmi(7'h20, 0, 0, rd, er);
      check("bad_addr_err", er, 1);
      check("bad_addr_rdata", rd, 0);
      dmi(7'h11, 1, 32'hFFFF_FFFF, rd, er);
      check("dmstatus_write_err", er, 0);

      dmi(7'h10, 1, 32'h0000_0001, rd, er);
      dmi(7'h10, 1, 32'h0000_0003, rd, er);
      rsp_ready = 1'b0;
      dmi(7'h10, 0, 0, rd, er);
      check("hold_rdata", rd, 32'h0000_0003);
      held = rd;
      for (int k = 0; k < 5; k++) begin
         check("hold_valid", rsp_valid, 1);
         check("hold_data", rsp_rdata, held);
         check("hold_ready", req_ready, 0);
         @(negedge clk);
      end
      #2 rst = 1'b0;
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_outputs", {halt_req, resume_req, ndmreset, dmactive, rsp_err}, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int c = 0; c < 4000; c++) begin
         int r;
         rsp_ready = ($urandom % 4) != 0;
         if (req_valid && m_acc) req_valid = 1'b0;
         if (!req_valid && ($urandom % 2) == 0) begin
            r = int'($urandom % 8);
            req_addr  = (r < 3) ? 7'h10 : (r < 6) ? 7'h11 : 7'($urandom % 128);
            req_wr    = ($urandom % 3) != 0;
            req_wdata = $urandom;
            req_wdata[0] = ($urandom % 8) != 0;
            req_wdata[19:16] = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'($urandom % 2);
            req_valid = 1'b1;
         end
         for (int i = 0; i < NH; i++) begin
            if (m_hp[i] && ($urandom % 3) == 0)      halted[i] = 1'b1;
            else if (m_rp[i] && ($urandom % 3) == 0) halted[i] = 1'b0;
            else if (($urandom % 64) == 0)           halted[i] = ~halted[i];
         end
         @(negedge clk);
      end

      rsp_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (req_valid && m_acc) req_valid = 1'b0;
         @(negedge clk);
      end
      req_valid = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
